// File: rtl/ser2par_align_pkg.sv
// Shared definitions for the 10-bit serial link receive side: comma codes,
// aligner state encoding and a small sizing helper.
package ser2par_align_pkg;

   localparam int         WORD_W  = 10;
   localparam logic [9:0] COMMA_P = 10'h17C;
   localparam logic [9:0] COMMA_N = 10'h283;

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_SYNC   = 2'd1,
      S_LOCKED = 2'd2
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ser2par_align_comma_det.sv
// Combinational K28.5 comma detector on a 10-bit window (bit0 = oldest bit).
// hit flags either running disparity; hit_pos_polarity flags the 17C form only.
module comma_det
   import ser2par_align_pkg::*;
(
   input  logic [WORD_W-1:0] nsr,
   output logic              hit,
   output logic              hit_pos_polarity
);

   logic hit_p_s;
   logic hit_n_s;

   assign hit_p_s          = (nsr == COMMA_P);
   assign hit_n_s          = (nsr == COMMA_N);
   assign hit              = hit_p_s | hit_n_s;
   assign hit_pos_polarity = hit_p_s;

endmodule

// File: rtl/ser2par_align.sv
// Serial-to-parallel receiver that hunts for the K28.5 comma at any bit offset,
// locks the word boundary to it and emits aligned 10-bit words with lock status.
module ser2par_align
   import ser2par_align_pkg::*;
#(
   parameter int WIDTH       = WORD_W,
   parameter int LOCK_COMMAS = 3,
   parameter int LOSS_COMMAS = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             INP_SER,
   input  logic             NEG,
   output logic [WIDTH-1:0] OUT_PAR,
   output logic             WORD_VAL,
   output logic             COMMA,
   output logic             LOCKED
);

   localparam int              CNT_W    = $clog2(max_int(LOCK_COMMAS, LOSS_COMMAS) + 1);
   localparam logic [CNT_W:0]  LOCK_N   = (CNT_W+1)'(LOCK_COMMAS);
   localparam logic [CNT_W:0]  LOSS_N   = (CNT_W+1)'(LOSS_COMMAS);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(1'b0);
   localparam logic [3:0]      LAST_BIT = 4'(WIDTH - 1);

   logic [WIDTH-1:0] sr_r;
   logic [3:0]       bit_cnt_r;
   state_e           state_r;
   state_e           state_n;
   logic [CNT_W-1:0] good_r;
   logic [CNT_W-1:0] good_n;
   logic [CNT_W-1:0] bad_r;
   logic [CNT_W-1:0] bad_n;
   logic [WIDTH-1:0] out_par_r;
   logic             word_val_r;
   logic             comma_r;
   logic             locked_r;

   logic             b_s;
   logic [WIDTH-1:0] nsr_s;
   logic             hit_s;
   logic             hit_pos_s;
   logic             hit_neg_s;
   logic             boundary_s;
   logic             emit_s;
   logic             realign_s;
   logic [CNT_W:0]   good_inc_s;
   logic [CNT_W:0]   bad_inc_s;
   logic [CNT_W-1:0] good_sat_s;

   // Polarity swap applies to the bit entering on this edge only.
   assign b_s        = INP_SER ^ NEG;
   assign nsr_s      = {b_s, sr_r[WIDTH-1:1]};
   assign boundary_s = (bit_cnt_r == LAST_BIT);
   assign hit_neg_s  = hit_s & ~hit_pos_s;
   assign good_inc_s = {1'b0, good_r} + (CNT_W+1)'(1'b1);
   assign bad_inc_s  = {1'b0, bad_r} + (CNT_W+1)'(1'b1);
   assign good_sat_s = (good_inc_s >= LOCK_N) ? LOCK_N[CNT_W-1:0] : good_inc_s[CNT_W-1:0];

   comma_det u_comma_det (
      .nsr              (nsr_s),
      .hit              (hit_s),
      .hit_pos_polarity (hit_pos_s)
   );

   // Next-state, counter updates, emit and realign decisions.
   always_comb begin
      state_n   = state_r;
      good_n    = good_r;
      bad_n     = bad_r;
      emit_s    = 1'b0;
      realign_s = 1'b0;
      case (state_r)
         S_HUNT: begin
            if (hit_s) begin
               realign_s = 1'b1;
               emit_s    = 1'b1;
               good_n    = ONE_C;
               bad_n     = ZERO_C;
               state_n   = (LOCK_COMMAS == 1) ? S_LOCKED : S_SYNC;
            end else begin
               state_n = S_HUNT;
            end
         end
         S_SYNC: begin
            if (boundary_s) begin
               emit_s = 1'b1;
               if (hit_s) begin
                  good_n  = good_sat_s;
                  state_n = (good_inc_s == LOCK_N) ? S_LOCKED : S_SYNC;
               end else begin
                  good_n = good_r;
               end
            end else if (hit_s) begin
               // Off-boundary comma restarts the qualification on the new boundary.
               realign_s = 1'b1;
               emit_s    = 1'b1;
               good_n    = ONE_C;
            end else begin
               emit_s = 1'b0;
            end
         end
         S_LOCKED: begin
            if (boundary_s) begin
               emit_s = 1'b1;
               bad_n  = hit_s ? ZERO_C : bad_r;
            end else if (hit_s) begin
               if (bad_inc_s == LOSS_N) begin
                  state_n = S_HUNT;
                  bad_n   = ZERO_C;
                  good_n  = ZERO_C;
               end else begin
                  bad_n = bad_inc_s[CNT_W-1:0];
               end
            end else begin
               bad_n = bad_r;
            end
         end
         default: begin
            state_n = S_HUNT;
            good_n  = ZERO_C;
            bad_n   = ZERO_C;
         end
      endcase
   end

   // Shift register, word counter, FSM state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_r       <= '0;
         bit_cnt_r  <= 4'd0;
         state_r    <= S_HUNT;
         good_r     <= ZERO_C;
         bad_r      <= ZERO_C;
         out_par_r  <= '0;
         word_val_r <= 1'b0;
         comma_r    <= 1'b0;
         locked_r   <= 1'b0;
      end else begin
         sr_r       <= nsr_s;
         bit_cnt_r  <= (realign_s || boundary_s) ? 4'd0 : bit_cnt_r + 4'd1;
         state_r    <= state_n;
         good_r     <= good_n;
         bad_r      <= bad_n;
         out_par_r  <= emit_s ? nsr_s : out_par_r;
         word_val_r <= emit_s;
         comma_r    <= emit_s & (hit_pos_s | hit_neg_s);
         locked_r   <= (state_n == S_LOCKED);
      end
   end

   assign OUT_PAR  = out_par_r;
   assign WORD_VAL = word_val_r;
   assign COMMA    = comma_r;
   assign LOCKED   = locked_r;

endmodule

// File: tb/tb_ser2par_align.sv
// Directed bench for ser2par_align: reset, lock, polarity, realign, loss and a
// loopback-style word stream, all with hand-derived expectations.
module tb_ser2par_align;
   import ser2par_align_pkg::*;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       INP_SER = 1'b0;
   logic       NEG     = 1'b0;
   logic [9:0] OUT_PAR;
   logic       WORD_VAL;
   logic       COMMA;
   logic       LOCKED;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ser2par_align dut (
      .clk      (clk),
      .reset    (reset),
      .INP_SER  (INP_SER),
      .NEG      (NEG),
      .OUT_PAR  (OUT_PAR),
      .WORD_VAL (WORD_VAL),
      .COMMA    (COMMA),
      .LOCKED   (LOCKED)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      INP_SER = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic expect_word(input string tag, input logic [9:0] par, input logic cm, input logic lk);
      check({tag, "_val"},    {31'd0, WORD_VAL}, 32'd1);
      check({tag, "_par"},    {22'd0, OUT_PAR},  {22'd0, par});
      check({tag, "_comma"},  {31'd0, COMMA},    {31'd0, cm});
      check({tag, "_locked"}, {31'd0, LOCKED},   {31'd0, lk});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Sends 3 junk bits then comma/data/comma/data/comma, optionally bit-inverted.
   task automatic run_lock_seq(input string tag, input logic inv, input logic [9:0] c, input logic [9:0] d);
      logic [9:0] cw;
      logic [9:0] dw;
      cw = COMMA_P ^ {10{inv}};
      dw = 10'h035 ^ {10{inv}};
      for (int i = 0; i < 3; i++) send_bit(inv);
      check({tag, "_hunt_quiet"}, {31'd0, WORD_VAL}, 32'd0);
      for (int i = 0; i < 9; i++) send_bit(cw[i]);
      check({tag, "_no_early_word"}, {31'd0, WORD_VAL}, 32'd0);
      send_bit(cw[9]);
      expect_word({tag, "_w0"}, c, 1'b1, 1'b0);
      send_word(dw);
      expect_word({tag, "_w1"}, d, 1'b0, 1'b0);
      send_word(cw);
      expect_word({tag, "_w2"}, c, 1'b1, 1'b0);
      send_word(dw);
      expect_word({tag, "_w3"}, d, 1'b0, 1'b0);
      send_word(cw);
      expect_word({tag, "_w4"}, c, 1'b1, 1'b1);
   endtask

   function automatic int max_run(input logic [9:0] w);
      int best;
      int cur;
      best = 1;
      cur  = 1;
      for (int i = 1; i < 10; i++) begin
         if (w[i] == w[i-1]) cur++;
         else cur = 1;
         if (cur > best) best = cur;
      end
      return best;
   endfunction

   initial begin
      logic [9:0] w;
      logic       is_comma;

      // Power-up reset
      #12;
      check("init_outpar", {22'd0, OUT_PAR}, 32'd0);
      check("init_locked", {31'd0, LOCKED}, 32'd0);
      do_reset();

      // Lock on plain stream
      NEG = 1'b0;
      run_lock_seq("lock", 1'b0, 10'h17C, 10'h035);

      // Asynchronous reset mid-word while locked
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      #2 reset = 1'b1;
      #1;
      check("rst_outpar", {22'd0, OUT_PAR}, 32'd0);
      check("rst_val",    {31'd0, WORD_VAL}, 32'd0);
      check("rst_comma",  {31'd0, COMMA}, 32'd0);
      check("rst_locked", {31'd0, LOCKED}, 32'd0);
      check("rst_state",  {30'd0, dut.state_r}, {30'd0, S_HUNT});
      #1 reset = 1'b0;

      // Inverted stream corrected by NEG
      do_reset();
      NEG = 1'b1;
      run_lock_seq("neg1", 1'b1, 10'h17C, 10'h035);

      // Inverted stream without correction locks on the other disparity
      do_reset();
      NEG = 1'b0;
      run_lock_seq("neg0", 1'b1, 10'h283, 10'h3CA);

      // One-bit slip while in SYNC
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      send_word(COMMA_P);
      expect_word("slip_c0", 10'h17C, 1'b1, 1'b0);
      send_bit(1'b0);
      send_word(COMMA_P);
      expect_word("slip_realign", 10'h17C, 1'b1, 1'b0);
      send_word(COMMA_P);
      expect_word("slip_c2", 10'h17C, 1'b1, 1'b0);
      send_word(COMMA_P);
      expect_word("slip_c3", 10'h17C, 1'b1, 1'b1);

      // Loss of lock: off-boundary commas, with an aligned one clearing the count
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      for (int k = 0; k < 3; k++) send_word(COMMA_P);
      check("loss_locked0", {31'd0, LOCKED}, 32'd1);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      for (int k = 0; k < 3; k++) send_word(COMMA_P);
      check("loss_3off_locked", {31'd0, LOCKED}, 32'd1);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      send_word(COMMA_P);
      expect_word("loss_aligned", 10'h17C, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      for (int k = 0; k < 3; k++) send_word(COMMA_P);
      check("loss_3off_again", {31'd0, LOCKED}, 32'd1);
      send_word(COMMA_P);
      check("loss_4th_unlock", {31'd0, LOCKED}, 32'd0);
      check("loss_4th_noemit", {31'd0, WORD_VAL}, 32'd0);

      // Loopback-style stream: commas, then words whose bit runs cannot fake a comma
      do_reset();
      send_word(COMMA_P);
      expect_word("lb_c0", 10'h17C, 1'b1, 1'b0);
      send_word(COMMA_P);
      send_word(COMMA_P);
      expect_word("lb_c2", 10'h17C, 1'b1, 1'b1);
      for (int n = 0; n < 1024; n++) begin
         w        = n[9:0];
         is_comma = (w == COMMA_P) || (w == COMMA_N);
         if (is_comma || (max_run(w) <= 2)) begin
            for (int i = 0; i < 9; i++) begin
               send_bit(w[i]);
               check("lb_gap", {31'd0, WORD_VAL}, 32'd0);
            end
            send_bit(w[9]);
            expect_word("lb_word", w, is_comma, 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
